// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong: single-clock ping-pong frame store with deferred bank swap.
// Define FB_ADDR_CHECK_EN to add the sticky addr_err output and range-checked accesses.
module frame_buffer_pingpong #(
    parameter int PIXEL_WIDTH  = 24,
    parameter int IMG_WIDTH    = 176,
    parameter int IMG_HEIGHT   = 240,
    parameter int NUM_RD_PORTS = 2,
    parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                we,
    input  logic [ADDR_WIDTH-1:0]               wAddr,
    input  logic [PIXEL_WIDTH-1:0]              wData,
    input  logic                                wr_frame_done,
    output logic                                wr_stall,
    input  logic                                rd_hold,
    input  logic [NUM_RD_PORTS-1:0]             oe,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]  rAddr,
    output logic [NUM_RD_PORTS*PIXEL_WIDTH-1:0] rData,
    output logic [NUM_RD_PORTS-1:0]             rValid,
    output logic                                frame_ready,
    output logic                                swap,
`ifdef FB_ADDR_CHECK_EN
    output logic                                frame_overrun,
    output logic                                addr_err
`else
    output logic                                frame_overrun
`endif
);

    logic wr_bank;
    logic swap_pending;
    logic swap_go;
    logic wr_ok;

    logic [PIXEL_WIDTH-1:0] mem [0:1][0:TOTAL_PIXELS-1];

`ifdef FB_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] PIX_LIM = (ADDR_WIDTH+1)'(TOTAL_PIXELS);

    logic                    wr_bad;
    logic [NUM_RD_PORTS-1:0] rd_bad;

    assign wr_bad = we && ({1'b0, wAddr} >= PIX_LIM);
    assign wr_ok  = we && !swap_pending && !wr_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) addr_err <= 1'b0;
        else          addr_err <= addr_err | wr_bad | (|rd_bad);
    end
`else
    assign wr_ok = we && !swap_pending;
`endif

    // A pending swap or a fresh request both swap immediately unless readers hold.
    assign swap_go  = (swap_pending | wr_frame_done) & ~rd_hold;
    assign wr_stall = swap_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank       <= 1'b0;
            swap_pending  <= 1'b0;
            frame_ready   <= 1'b0;
            swap          <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            wr_bank       <= wr_bank ^ swap_go;
            swap          <= swap_go;
            frame_overrun <= wr_frame_done & swap_pending;
            if (swap_go) begin
                swap_pending <= 1'b0;
                frame_ready  <= 1'b1;
            end else if (wr_frame_done) begin
                swap_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_bank][wAddr] <= wData;
    end

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0]  ra;
        logic [PIXEL_WIDTH-1:0] rd_q;
        logic                   vld_q;
        logic                   rd_in;

        assign ra = rAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef FB_ADDR_CHECK_EN
        assign rd_in     = {1'b0, ra} < PIX_LIM;
        assign rd_bad[i] = oe[i] & ~rd_in;
`else
        assign rd_in = 1'b1;
`endif

        // Bank is sampled with oe, so a read in the swap cycle sees the old front.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else if (oe[i] && rd_in) begin
                rd_q  <= mem[~wr_bank][ra];
                vld_q <= frame_ready;
            end else if (oe[i]) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= 1'b0;
            end
        end

        assign rData[i*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_q;
        assign rValid[i] = vld_q;
    end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// tb_frame_buffer_pingpong: directed bench with a read-result scoreboard queue.
// Covers swap latency, hold/stall, overrun and swap-cycle reads.
module tb_frame_buffer_pingpong;

    localparam int PW = 24;
    localparam int AW = 16;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            we = 1'b0;
    logic [AW-1:0]   wAddr = '0;
    logic [PW-1:0]   wData = '0;
    logic            wr_frame_done = 1'b0;
    logic            wr_stall;
    logic            rd_hold = 1'b0;
    logic [NP-1:0]   oe = '0;
    logic [NP*AW-1:0] rAddr = '0;
    logic [NP*PW-1:0] rData;
    logic [NP-1:0]   rValid;
    logic            frame_ready;
    logic            swap;
    logic            frame_overrun;
`ifdef FB_ADDR_CHECK_EN
    logic            addr_err;
`endif

    frame_buffer_pingpong dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
        .wr_frame_done(wr_frame_done), .wr_stall(wr_stall), .rd_hold(rd_hold),
        .oe(oe), .rAddr(rAddr), .rData(rData), .rValid(rValid),
        .frame_ready(frame_ready), .swap(swap),
`ifdef FB_ADDR_CHECK_EN
        .frame_overrun(frame_overrun), .addr_err(addr_err)
`else
        .frame_overrun(frame_overrun)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [23:0] data;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nswap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [23:0] d, input logic v, input string tag);
        exp_t e;
        e.port = p; e.data = d; e.valid = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        oe[p] = 1'b1;
        rAddr[p*AW +: AW] = a;
    endtask

    // Advance one edge, then retire every expected read result in the queue.
    task automatic tick_chk();
        exp_t e;
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.valid)
                chk({e.tag, "_data"}, 64'(rData[e.port*PW +: PW]), 64'(e.data));
            chk({e.tag, "_vld"}, 64'(rValid[e.port]), 64'(e.valid));
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
        we = 1'b1; wAddr = a; wData = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(); tick();
        chk("rst_rdata", 64'(rData), 64'h0);
        chk("rst_rvalid", 64'(rValid), 64'h0);
        chk("rst_ready", 64'(frame_ready), 64'h0);
        chk("rst_stall", 64'(wr_stall), 64'h0);
        chk("rst_swap", 64'(swap), 64'h0);
        chk("rst_ovr", 64'(frame_overrun), 64'h0);
        reset_n = 1'b1;
        tick();

        // Reads before any frame: never valid.
        set_rd(0, 16'd0); set_rd(1, 16'd5);
        push(0, 24'h0, 1'b0, "pre_p0");
        push(1, 24'h0, 1'b0, "pre_p1");
        tick_chk();
        oe = '0;
        chk("pre_ready", 64'(frame_ready), 64'h0);

        // Fill bank0; last write coincides with the frame-done request.
        wr(16'd0, 24'h000011);
        wr(16'd1, 24'h000022);
        wr(16'd2, 24'h000033);
        we = 1'b1; wAddr = 16'd3; wData = 24'h000044; wr_frame_done = 1'b1;
        tick();
        we = 1'b0; wr_frame_done = 1'b0;
        chk("sw1_swap", 64'(swap), 64'h1);
        chk("sw1_ready", 64'(frame_ready), 64'h1);
        chk("sw1_stall", 64'(wr_stall), 64'h0);
        tick();
        chk("sw1_swap_off", 64'(swap), 64'h0);

        set_rd(0, 16'd2); set_rd(1, 16'd3);
        push(0, 24'h000033, 1'b1, "rd_a2");
        push(1, 24'h000044, 1'b1, "rd_a3");
        tick_chk();
        set_rd(0, 16'd1); set_rd(1, 16'd1);
        push(0, 24'h000022, 1'b1, "same_p0");
        push(1, 24'h000022, 1'b1, "same_p1");
        tick_chk();
        oe = '0;
        push(0, 24'h000022, 1'b0, "hold_p0");
        tick_chk();
        chk("hold_p0_keep", 64'(rData[PW-1:0]), 64'h000022);

        // Fill bank1, then request with readers holding.
        wr(16'd0, 24'hA0A0A0);
        wr(16'd1, 24'hB1B1B1);
        rd_hold = 1'b1; wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        chk("hold_stall", 64'(wr_stall), 64'h1);
        chk("hold_noswap", 64'(swap), 64'h0);
        wr(16'd0, 24'hFFFFFF);
        chk("hold_noswap2", 64'(swap), 64'h0);
        set_rd(0, 16'd0);
        push(0, 24'h000011, 1'b1, "hold_old");
        tick_chk();
        oe = '0;
        rd_hold = 1'b0;
        tick();
        chk("rel_swap", 64'(swap), 64'h1);
        chk("rel_stall", 64'(wr_stall), 64'h0);
        set_rd(0, 16'd0);
        push(0, 24'hA0A0A0, 1'b1, "drop_chk");
        tick_chk();
        oe = '0;

        // Two requests under hold: one overrun, one swap.
        rd_hold = 1'b1; wr_frame_done = 1'b1;
        tick();
        chk("ovr_first", 64'(frame_overrun), 64'h0);
        tick();
        wr_frame_done = 1'b0;
        chk("ovr_second", 64'(frame_overrun), 64'h1);
        chk("ovr_stall", 64'(wr_stall), 64'h1);
        tick();
        chk("ovr_pulse_end", 64'(frame_overrun), 64'h0);
        rd_hold = 1'b0;
        nswap = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            nswap += int'(swap);
        end
        chk("ovr_one_swap", 64'(nswap), 64'h1);

        // Back bank is bank1 now; read in the swap-generation cycle sees bank0.
        wr(16'd0, 24'hC0C0C0);
        wr_frame_done = 1'b1;
        set_rd(1, 16'd0);
        push(1, 24'h000011, 1'b1, "swapcyc_old");
        tick_chk();
        wr_frame_done = 1'b0;
        chk("swapcyc_swap", 64'(swap), 64'h1);
        push(1, 24'hC0C0C0, 1'b1, "swapcyc_new");
        tick_chk();
        oe = '0;

`ifdef FB_ADDR_CHECK_EN
        chk("aerr_clear", 64'(addr_err), 64'h0);
        wr(16'd42240, 24'h123456);
        chk("aerr_wr", 64'(addr_err), 64'h1);
        set_rd(0, 16'd50000);
        tick();
        chk("aerr_rdata", 64'(rData[PW-1:0]), 64'h0);
        chk("aerr_rvld", 64'(rValid[0]), 64'h0);
        oe = '0;
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
